// File: rtl/ds_operand_stage.sv
// Decode-to-execute operand stage: holds one decoded instruction and resolves its source
// operands from the register file or the youngest matching forwarding source.
module ds_operand_stage #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NFWD = 3,
  parameter int PW   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_allowin,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [AW-1:0]        in_rs1,
  input  logic [AW-1:0]        in_rs2,
  input  logic                 in_use1,
  input  logic                 in_use2,
  input  logic [AW-1:0]        in_dest,
  input  logic                 in_we,
  input  logic [PW-1:0]        in_payload,
  output logic [AW-1:0]        rf_raddr1,
  output logic [AW-1:0]        rf_raddr2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_dest,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_data_ok,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_allowin,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_src1,
  output logic [XLEN-1:0]      out_src2,
  output logic [AW-1:0]        out_dest,
  output logic                 out_we,
  output logic [PW-1:0]        out_payload,
  output logic [31:0]          perf_stall_cnt
);

  logic            dsValid_q, dsValid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [AW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, dest_q, dest_d;
  logic            use1_q, use1_d, use2_q, use2_d, we_q, we_d;
  logic [PW-1:0]   payload_q, payload_d;
  logic [31:0]     stallCnt_q, stallCnt_d;

  logic [1:0][AW-1:0]   rsSel;
  logic [1:0]           useSel;
  logic [1:0][XLEN-1:0] rfSel;
  logic [1:0][XLEN-1:0] operand;
  logic [1:0]           stall;
  logic                 readyGo;
  logic                 load;

  // Walk sources oldest to youngest so the youngest match overwrites; its readiness alone
  // decides the interlock, even if an older source already holds a ready value.
  always_comb begin
    rsSel  = {rs2_q, rs1_q};
    useSel = {use2_q, use1_q};
    rfSel  = {rf_rdata2, rf_rdata1};
    operand = '0;
    stall   = '0;
    for (int s = 0; s < 2; s++) begin
      operand[s] = rfSel[s];
      for (int i = NFWD - 1; i >= 0; i--) begin
        if (fwd_valid[i] && fwd_we[i] && (fwd_dest[i*AW +: AW] == rsSel[s]) &&
            (rsSel[s] != '0) && useSel[s]) begin
          operand[s] = fwd_data[i*XLEN +: XLEN];
          stall[s]   = ~fwd_data_ok[i];
        end
      end
      if (rsSel[s] == '0) operand[s] = '0;
    end
  end

  assign readyGo    = ~(stall[0] | stall[1]);
  assign in_allowin = ~dsValid_q | (readyGo & out_allowin);
  assign out_valid  = dsValid_q & readyGo & ~flush;
  assign load       = in_allowin & in_valid & ~flush;

  always_comb begin
    dsValid_d  = dsValid_q;
    pc_d       = pc_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    use1_d     = use1_q;
    use2_d     = use2_q;
    dest_d     = dest_q;
    we_d       = we_q;
    payload_d  = payload_q;
    stallCnt_d = stallCnt_q;
    if (flush)           dsValid_d = 1'b0;
    else if (in_allowin) dsValid_d = in_valid;
    if (load) begin
      pc_d      = in_pc;
      rs1_d     = in_rs1;
      rs2_d     = in_rs2;
      use1_d    = in_use1;
      use2_d    = in_use2;
      dest_d    = in_dest;
      we_d      = in_we;
      payload_d = in_payload;
    end
    if (dsValid_q && !readyGo && !flush && (stallCnt_q != 32'hFFFF_FFFF))
      stallCnt_d = stallCnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dsValid_q  <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      use1_q     <= 1'b0;
      use2_q     <= 1'b0;
      dest_q     <= '0;
      we_q       <= 1'b0;
      payload_q  <= '0;
      stallCnt_q <= '0;
    end else begin
      dsValid_q  <= dsValid_d;
      pc_q       <= pc_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      use1_q     <= use1_d;
      use2_q     <= use2_d;
      dest_q     <= dest_d;
      we_q       <= we_d;
      payload_q  <= payload_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign rf_raddr1      = rs1_q;
  assign rf_raddr2      = rs2_q;
  assign out_pc         = pc_q;
  assign out_src1       = operand[0];
  assign out_src2       = operand[1];
  assign out_dest       = dest_q;
  assign out_we         = we_q;
  assign out_payload    = payload_q;
  assign perf_stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_ds_operand_stage.sv
// Scoreboard bench for ds_operand_stage: each accepted instruction queues its expected
// resolved operands and is compared when the stage hands it to execute.
module tb_ds_operand_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;
    logic        we;
    logic [63:0] payload;
  } exp_t;

  logic        clk, reset, in_valid, in_allowin;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1, in_rs2, in_dest;
  logic        in_use1, in_use2, in_we;
  logic [63:0] in_payload;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [2:0]  fwd_valid, fwd_we, fwd_data_ok;
  logic [14:0] fwd_dest;
  logic [95:0] fwd_data;
  logic        flush, out_valid, out_allowin;
  logic [31:0] out_pc, out_src1, out_src2;
  logic [4:0]  out_dest;
  logic        out_we;
  logic [63:0] out_payload;
  logic [31:0] perf_stall_cnt;

  int          compared = 0;
  int          mismatched = 0;
  exp_t        sbQ[$];
  logic [31:0] expCnt = 0;
  logic [31:0] pcCtr = 32'h1000;

  ds_operand_stage #(.XLEN(32), .AW(5), .NFWD(3), .PW(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_allowin(in_allowin),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use1(in_use1), .in_use2(in_use2),
    .in_dest(in_dest), .in_we(in_we), .in_payload(in_payload),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .fwd_data_ok(fwd_data_ok), .flush(flush), .out_valid(out_valid), .out_allowin(out_allowin),
    .out_pc(out_pc), .out_src1(out_src1), .out_src2(out_src2), .out_dest(out_dest),
    .out_we(out_we), .out_payload(out_payload), .perf_stall_cnt(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearFwd();
    fwd_valid = '0; fwd_we = '0; fwd_dest = '0; fwd_data = '0; fwd_data_ok = '0;
  endtask

  // Presents one instruction upstream and returns its expected fields (operands filled by caller).
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, output exp_t e);
    in_valid   = 1'b1;
    in_pc      = pcCtr;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_use1    = u1;
    in_use2    = u2;
    in_dest    = 5'($urandom_range(1, 31));
    in_we      = 1'($urandom);
    in_payload = {$urandom, $urandom};
    e = '{pc: pcCtr, src1: 32'h0, src2: 32'h0, dest: in_dest, we: in_we, payload: in_payload};
    pcCtr = pcCtr + 32'd4;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_use1 = 1'b0;
    in_use2 = 1'b0; in_dest = '0; in_we = 1'b0; in_payload = '0; flush = 1'b0;
    out_allowin = 1'b1; rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
    clearFwd();
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if ({out_valid, in_allowin} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL reset_handshake: got valid/allowin=%b expected 01", {out_valid, in_allowin});
    end
    compared++;
    if ({rf_raddr1, rf_raddr2, out_pc, out_src1, out_src2, out_dest, out_we, out_payload} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_fields: got pc=%h src1=%h src2=%h raddr1=%h expected all zero",
               out_pc, out_src1, out_src2, rf_raddr1);
    end
    compared++;
    if (perf_stall_cnt !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_cnt: got %0d expected 0", perf_stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, a;
    clearFwd();
    tick();
    drive(5'd3, 5'd4, 1'b1, 1'b1, e);
    e.src1 = 32'h11; e.src2 = 32'h22;
    sbQ.push_back(e);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k < 3) begin
        drive(5'd3, 5'd4, 1'b1, 1'b1, e);
        e.src1 = 32'h11; e.src2 = 32'h22;
        sbQ.push_back(e);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      compared++;
      if ({out_valid, in_allowin, rf_raddr1, rf_raddr2} !== {2'b11, 5'd3, 5'd4}) begin
        mismatched++;
        $display("[TB] FAIL b2b_flow[%0d]: got valid/allowin=%b raddr=%0d/%0d expected 11 3/4",
                 k, {out_valid, in_allowin}, rf_raddr1, rf_raddr2);
      end
      a = {out_pc, out_src1, out_src2, out_dest, out_we, out_payload};
      e = (sbQ.size() != 0) ? sbQ.pop_front() : '0;
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", k, a, e);
      end
    end
    tick();
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0 || sbQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL b2b_drain: got valid=%b queued=%0d expected 0/0", out_valid, sbQ.size());
    end
  endtask

  task automatic test_priority_forward();
    exp_t e, a;
    tick();
    fwd_valid = 3'b101; fwd_we = 3'b101; fwd_data_ok = 3'b101;
    fwd_dest = {5'd5, 5'd0, 5'd5};
    fwd_data = {32'hBBBB, 32'h0, 32'hAAAA};
    drive(5'd5, 5'd4, 1'b1, 1'b1, e);
    e.src1 = 32'hAAAA; e.src2 = 32'h22;
    sbQ.push_back(e);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL prio_valid: got %b expected 1", out_valid);
    end
    a = {out_pc, out_src1, out_src2, out_dest, out_we, out_payload};
    e = (sbQ.size() != 0) ? sbQ.pop_front() : '0;
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("[TB] FAIL prio_data: got src1=%h expected src1=%h (full %h vs %h)", a.src1, e.src1, a, e);
    end
    clearFwd();
  endtask

  task automatic test_load_use();
    exp_t e, a;
    tick();
    drive(5'd3, 5'd7, 1'b1, 1'b1, e);
    e.src1 = 32'h11; e.src2 = 32'h1234;
    sbQ.push_back(e);
    tick();
    in_valid = 1'b0;
    // Younger load not ready while an older stale copy is ready: must still interlock.
    fwd_valid = 3'b011; fwd_we = 3'b011; fwd_data_ok = 3'b010;
    fwd_dest = {5'd0, 5'd7, 5'd7};
    fwd_data = {32'h0, 32'h9999, 32'hDEAD};
    @(negedge clk);
    compared++;
    if ({out_valid, in_allowin} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL loaduse_stall: got valid/allowin=%b expected 00", {out_valid, in_allowin});
    end
    expCnt = expCnt + 32'd1;
    tick();
    fwd_valid = 3'b010; fwd_we = 3'b010; fwd_data_ok = 3'b010;
    fwd_dest = {5'd0, 5'd7, 5'd0};
    fwd_data = {32'h0, 32'h1234, 32'h0};
    @(negedge clk);
    compared++;
    if ({out_valid, perf_stall_cnt} !== {1'b1, expCnt}) begin
      mismatched++;
      $display("[TB] FAIL loaduse_release: got valid=%b cnt=%0d expected 1 %0d", out_valid, perf_stall_cnt, expCnt);
    end
    a = {out_pc, out_src1, out_src2, out_dest, out_we, out_payload};
    e = (sbQ.size() != 0) ? sbQ.pop_front() : '0;
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("[TB] FAIL loaduse_data: got src2=%h expected src2=%h", a.src2, e.src2);
    end
    clearFwd();
  endtask

  task automatic test_r0_gating();
    exp_t e, a;
    tick();
    fwd_valid = 3'b101; fwd_we = 3'b111; fwd_data_ok = 3'b000;
    fwd_dest = {5'd9, 5'd6, 5'd0};
    fwd_data = {32'h7777, 32'h6666, 32'h5555};
    drive(5'd0, 5'd9, 1'b1, 1'b0, e);
    e.src1 = 32'h0; e.src2 = 32'h22;
    sbQ.push_back(e);
    tick();
    drive(5'd6, 5'd4, 1'b1, 1'b1, e);
    e.src1 = 32'h11; e.src2 = 32'h22;
    sbQ.push_back(e);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL gate_valid[%0d]: got %b expected 1", k, out_valid);
      end
      a = {out_pc, out_src1, out_src2, out_dest, out_we, out_payload};
      e = (sbQ.size() != 0) ? sbQ.pop_front() : '0;
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("[TB] FAIL gate_data[%0d]: got src1=%h src2=%h expected %h %h", k, a.src1, a.src2, e.src1, e.src2);
      end
      tick();
      in_valid = 1'b0;
    end
    compared++;
    if (perf_stall_cnt !== expCnt) begin
      mismatched++;
      $display("[TB] FAIL gate_cnt: got %0d expected %0d", perf_stall_cnt, expCnt);
    end
    clearFwd();
  endtask

  task automatic test_flush();
    exp_t e;
    tick();
    fwd_valid = 3'b001; fwd_we = 3'b001; fwd_data_ok = 3'b000;
    fwd_dest = {5'd0, 5'd0, 5'd7};
    drive(5'd7, 5'd4, 1'b1, 1'b1, e);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_prestall: got %b expected 0", out_valid);
    end
    expCnt = expCnt + 32'd1;
    tick();
    flush = 1'b1;
    drive(5'd3, 5'd4, 1'b1, 1'b1, e);
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_outvalid: got %b expected 0", out_valid);
    end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    clearFwd();
    @(negedge clk);
    compared++;
    if ({out_valid, in_allowin, perf_stall_cnt} !== {2'b01, expCnt}) begin
      mismatched++;
      $display("[TB] FAIL flush_after: got valid/allowin=%b cnt=%0d expected 01 %0d",
               {out_valid, in_allowin}, perf_stall_cnt, expCnt);
    end
  endtask

  task automatic test_backpressure_reset();
    exp_t e, eA, a;
    tick();
    drive(5'd3, 5'd4, 1'b1, 1'b1, eA);
    eA.src1 = 32'h11; eA.src2 = 32'h22;
    sbQ.push_back(eA);
    tick();
    out_allowin = 1'b0;
    drive(5'd8, 5'd9, 1'b1, 1'b1, e);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      compared++;
      if ({out_valid, in_allowin, out_pc, out_payload, perf_stall_cnt} !==
          {2'b10, eA.pc, eA.payload, expCnt}) begin
        mismatched++;
        $display("[TB] FAIL bp_hold[%0d]: got valid/allowin=%b pc=%h cnt=%0d expected 10 %h %0d",
                 j, {out_valid, in_allowin}, out_pc, perf_stall_cnt, eA.pc, expCnt);
      end
      tick();
    end
    out_allowin = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    a = {out_pc, out_src1, out_src2, out_dest, out_we, out_payload};
    e = (sbQ.size() != 0) ? sbQ.pop_front() : '0;
    compared++;
    if (out_valid !== 1'b1 || a !== e) begin
      mismatched++;
      $display("[TB] FAIL bp_release: got valid=%b %h expected 1 %h", out_valid, a, e);
    end
    tick();
    fwd_valid = 3'b001; fwd_we = 3'b001; fwd_data_ok = 3'b000;
    fwd_dest = {5'd0, 5'd0, 5'd7};
    drive(5'd7, 5'd4, 1'b1, 1'b1, e);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expCnt = 32'd0;
    @(negedge clk);
    compared++;
    if ({out_valid, in_allowin, perf_stall_cnt} !== {2'b01, 32'd0}) begin
      mismatched++;
      $display("[TB] FAIL midstall_reset: got valid/allowin=%b cnt=%0d expected 01 0",
               {out_valid, in_allowin}, perf_stall_cnt);
    end
    compared++;
    if ({rf_raddr1, rf_raddr2, out_pc, out_src1, out_src2, out_dest, out_we, out_payload} !== '0) begin
      mismatched++;
      $display("[TB] FAIL midstall_fields: got pc=%h raddr2=%0d payload=%h expected zeros",
               out_pc, rf_raddr2, out_payload);
    end
    clearFwd();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_priority_forward();
    test_load_use();
    test_r0_gating();
    test_flush();
    test_backpressure_reset();
    compared++;
    if (sbQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL sb_leftover: got %0d queued expected 0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
